// File: rtl/mul_seq_ctrl.sv
// Iterative radix-2 shift-add multiply sequencer for the EX stage.
// Freezes the pipeline for WIDTH+1 cycles and strobes the product once.
module mul_seq_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mul_ex_in,
  input  logic              mul_signed,
  input  logic              flush,
  input  logic [0:WIDTH-1]  op_a,
  input  logic [0:WIDTH-1]  op_b,
  input  logic [0:DEST_W-1] dest_ex,
  output logic              stall_out,
  output logic              busy,
  output logic              result_valid,
  output logic [0:WIDTH-1]  result_hi,
  output logic [0:WIDTH-1]  result_lo,
  output logic [0:DEST_W-1] result_dest
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic               neg;
  logic [CW-1:0]      count;
  logic [DEST_W-1:0]  dest_q;

  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]   mp_nx;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fin;
  logic               accept;
  logic               last;

  // Ports are MSB-at-index-0; positional assignment keeps the MSB on top.
  assign a_in = op_a;
  assign b_in = op_b;

  // -MIN wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag = a_in;
    b_mag = b_in;
    if (mul_signed && a_in[WIDTH-1]) a_mag = -a_in;
    if (mul_signed && b_in[WIDTH-1]) b_mag = -b_in;
  end

  always_comb begin
    sum = {1'b0, acc};
    if (mplier[0]) sum = {1'b0, acc} + {1'b0, mcand};
    acc_nx   = sum[WIDTH:1];
    mp_nx    = {sum[0], mplier[WIDTH-1:1]};
    prod     = {acc_nx, mp_nx};
    prod_fin = neg ? -prod : prod;
  end

  assign accept = (state == IDLE) && mul_ex_in && !flush;
  assign last   = (count == CW'(WIDTH - 1));

  assign stall_out =
    !reset && (accept || (state == RUN && !flush));

  assign result_valid = (state == DONE) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      count       <= '0;
      dest_q      <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      result_dest <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            neg    <= mul_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            dest_q <= dest_ex;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc    <= acc_nx;
            mplier <= mp_nx;
            count  <= count + 1'b1;
            if (last) begin
              result_hi   <= prod_fin[2*WIDTH-1:WIDTH];
              result_lo   <= prod_fin[WIDTH-1:0];
              result_dest <= dest_q;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: timing of stall/valid,
// signed/unsigned products, flush and reset aborts.
module tb_mul_seq_ctrl;

  localparam int W = 32;
  localparam int D = 5;

  logic         clk;
  logic         reset;
  logic         mul_ex_in;
  logic         mul_signed;
  logic         flush;
  logic [0:W-1] op_a;
  logic [0:W-1] op_b;
  logic [0:D-1] dest_ex;
  logic         stall_out;
  logic         busy;
  logic         result_valid;
  logic [0:W-1] result_hi;
  logic [0:W-1] result_lo;
  logic [0:D-1] result_dest;

  mul_seq_ctrl #(.WIDTH(W), .DEST_W(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .mul_ex_in    (mul_ex_in),
    .mul_signed   (mul_signed),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .dest_ex      (dest_ex),
    .stall_out    (stall_out),
    .busy         (busy),
    .result_valid (result_valid),
    .result_hi    (result_hi),
    .result_lo    (result_lo),
    .result_dest  (result_dest)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [D-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   nvec;
  int   nerr;
  int   nres;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input bit s,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [D-1:0] d);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    exp_t e;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p = ea * eb;
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.d  = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && result_valid) begin
      exp_t e;
      nres++;
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result_hi", 64'(result_hi), 64'(e.hi));
        chk("result_lo", 64'(result_lo), 64'(e.lo));
        chk("result_dest", 64'(result_dest), 64'(e.d));
      end
    end
  end

  task automatic drive(input bit s,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [D-1:0] d);
    reset      = 1'b0;
    flush      = 1'b0;
    mul_ex_in  = 1'b1;
    mul_signed = s;
    op_a       = a;
    op_b       = b;
    dest_ex    = d;
  endtask

  // Full-latency multiply; operands are scrambled after accept.
  task automatic run_mul(input bit s,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [D-1:0] d);
    exp_t e;
    tick();
    drive(s, a, b, d);
    e = model(s, a, b, d);
    sb.push_back(e);
    #5;
    chk("stall_accept", 64'(stall_out), 64'd1);
    chk("hold_hi", 64'(result_hi), 64'(last_exp.hi));
    chk("hold_lo", 64'(result_lo), 64'(last_exp.lo));
    for (int i = 1; i <= W; i++) begin
      tick();
      mul_ex_in  = 1'b0;
      mul_signed = 1'($urandom);
      op_a       = $urandom;
      op_b       = $urandom;
      dest_ex    = D'($urandom);
      #5;
      chk("stall_run", 64'(stall_out), 64'd1);
      chk("busy_run", 64'(busy), 64'd1);
      chk("valid_run", 64'(result_valid), 64'd0);
    end
    tick();
    #5;
    chk("stall_done", 64'(stall_out), 64'd0);
    chk("valid_done", 64'(result_valid), 64'd1);
    chk("busy_done", 64'(busy), 64'd1);
    tick();
    #5;
    chk("busy_after", 64'(busy), 64'd0);
    chk("valid_after", 64'(result_valid), 64'd0);
    last_exp = e;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(result_valid), 64'd0);
    chk({tag, "_stall"}, 64'(stall_out), 64'd0);
    chk({tag, "_hi"}, 64'(result_hi), 64'd0);
    chk({tag, "_lo"}, 64'(result_lo), 64'd0);
    chk({tag, "_dest"}, 64'(result_dest), 64'd0);
  endtask

  initial begin
    int r0;
    exp_t e;
    nvec = 0;
    nerr = 0;
    nres = 0;
    last_exp = '{hi: '0, lo: '0, d: '0};
    reset = 1'b1;
    flush = 1'b0;
    mul_ex_in = 1'b0;
    mul_signed = 1'b0;
    op_a = '0;
    op_b = '0;
    dest_ex = '0;
    repeat (3) tick();
    reset = 1'b0;
    #5;
    chk_zero("reset_state");

    run_mul(1'b0, 32'd3, 32'd5, 5'd7);
    run_mul(1'b1, 32'hFFFFFFFF, 32'h00000002, 5'd1);
    run_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31);
    run_mul(1'b1, 32'h80000000, 32'h80000000, 5'd12);
    run_mul(1'b1, 32'h80000000, 32'h00000001, 5'd19);
    run_mul(1'b1, 32'd0, 32'h12345678, 5'd2);
    for (int k = 0; k < 6; k++)
      run_mul(1'($urandom), $urandom, $urandom, D'($urandom));

    // Flush during RUN step 10, then a fresh multiply next cycle.
    tick();
    drive(1'b0, 32'hDEAD, 32'hBEEF, 5'd9);
    for (int i = 1; i <= 11; i++) begin
      tick();
      mul_ex_in = 1'b0;
    end
    flush = 1'b1;
    #5;
    chk("flush_stall", 64'(stall_out), 64'd0);
    run_mul(1'b1, 32'hFFFFFFF9, 32'd6, 5'd4);

    // Back-to-back with mul_ex_in held high through DONE.
    r0 = nres;
    tick();
    drive(1'b0, 32'd7, 32'd9, 5'd3);
    sb.push_back(model(1'b0, 32'd7, 32'd9, 5'd3));
    #5;
    chk("b2b_stall_t", 64'(stall_out), 64'd1);
    for (int i = 1; i <= W; i++) begin
      tick();
      #5;
      chk("b2b_stall_run", 64'(stall_out), 64'd1);
    end
    tick();
    op_a = 32'd11;
    op_b = 32'd13;
    dest_ex = 5'd4;
    #5;
    chk("b2b_no_reaccept", 64'(stall_out), 64'd0);
    chk("b2b_valid1", 64'(result_valid), 64'd1);
    sb.push_back(model(1'b0, 32'd11, 32'd13, 5'd4));
    tick();
    #5;
    chk("b2b_accept2", 64'(stall_out), 64'd1);
    chk("b2b_busy2", 64'(busy), 64'd0);
    for (int i = 1; i <= W; i++) begin
      tick();
      #5;
      chk("b2b_stall_run2", 64'(stall_out), 64'd1);
      chk("b2b_valid_run2", 64'(result_valid), 64'd0);
    end
    tick();
    mul_ex_in = 1'b0;
    #5;
    chk("b2b_valid2", 64'(result_valid), 64'd1);
    tick();
    #5;
    chk("b2b_count", 64'(nres - r0), 64'd2);
    chk("b2b_idle", 64'(busy), 64'd0);

    // Reset at RUN step 20.
    tick();
    drive(1'b1, 32'hFFFF0000, 32'h00007777, 5'd21);
    for (int i = 1; i <= 21; i++) begin
      tick();
      mul_ex_in = 1'b0;
    end
    reset = 1'b1;
    #5;
    chk("rst_run_stall", 64'(stall_out), 64'd0);
    tick();
    reset = 1'b0;
    #5;
    chk_zero("rst_run");

    // Reset in DONE, with a non-zero product already registered.
    tick();
    drive(1'b0, 32'h00012345, 32'h00000777, 5'd22);
    for (int i = 1; i <= W; i++) begin
      tick();
      mul_ex_in = 1'b0;
    end
    tick();
    reset = 1'b1;
    #5;
    chk("rst_done_stall", 64'(stall_out), 64'd0);
    tick();
    reset = 1'b0;
    #5;
    chk_zero("rst_done");

    last_exp = '{hi: '0, lo: '0, d: '0};
    run_mul(1'b0, 32'd100, 32'd200, 5'd30);
    repeat (2) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller for the shared iterative 32x32 multiplier in the pipeline EX stage. When a multiply instruction reaches EX (mul_ex_in), the block freezes the pipeline, runs a radix-2 shift-add multiply over WIDTH cycles, and releases the stall for exactly one cycle with the 64-bit product and its destination register. Squashed multiplies are aborted without writing back.

## Interface
- WIDTH, 32: operand width; also the number of iteration cycles.
- DEST_W, 5: destination register index width.

- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- mul_ex_in  in  1  EX stage holds a valid multiply instruction.
- mul_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled at accept.
- flush  in  1  squash the instruction in EX (branch/trap).
- op_a, op_b  in  [0:WIDTH-1]  operands, bit 0 = MSB; sampled at accept.
- dest_ex  in  [0:DEST_W-1]  destination register; sampled at accept.
- stall_out  out  1  freeze IF/ID/EX; combinational.
- busy  out  1  registered; high in RUN and DONE.
- result_valid  out  1  one-cycle product strobe for the EX/MEM latch.
- result_hi, result_lo  out  [0:WIDTH-1]  upper and lower halves of the product.
- result_dest  out  [0:DEST_W-1]  destination captured at accept.

## Operation
- States: IDLE, RUN, DONE. Reset is IDLE.
- IDLE: accept when mul_ex_in=1 and flush=0.
  - On accept, latch the magnitudes of op_a and op_b. Signed mode takes the absolute value; the magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - Latch neg = signed & (a[0] ^ b[0]), dest_ex, and count=0. Go to RUN.
- RUN: one step per cycle.
  - If the multiplier LSB is 1, add the multiplicand to the high accumulator.
  - Shift the {carry, acc, multiplier} register right by one.
  - count increments each step.
  - After step WIDTH-1, register the product into result_hi/lo, two's-complement negated over 64 bits if neg=1. Go to DONE.
- DONE: result_valid=1 unless flush=1. Go to IDLE unconditionally.
  - mul_ex_in is ignored in DONE, so the same instruction is never re-accepted.
- stall_out = (IDLE & mul_ex_in & ~flush) | (RUN & ~flush). It is 0 in DONE and 0 while reset=1.
- flush in RUN: abort. stall_out=0 that cycle, next state is IDLE, result_valid is never asserted, and result_hi/lo/dest keep their old values.
- flush in DONE: result_valid is gated to 0; return to IDLE.
- flush in IDLE together with mul_ex_in: no accept, no stall.
- reset at any state: next cycle IDLE; busy=0, result_valid=0, result_hi/lo=0, result_dest=0. The partial product is discarded.
- result_hi/lo/dest hold their values after DONE until the next completion.

## Timing
- Accept cycle T (IDLE, mul_ex_in=1, flush=0): stall_out=1 combinationally in T.
- RUN occupies T+1..T+WIDTH. stall_out=1 throughout, so the total stall is WIDTH+1 cycles (33 at default).
- DONE at T+WIDTH+1: result_valid=1, stall_out=0. The instruction advances to MEM at the end of that cycle.
- Back-to-back multiplies: the earliest next accept is T+WIDTH+2, so issue spacing is WIDTH+2 cycles.
- busy rises at T+1 and falls at T+WIDTH+2.
- No data-dependent early termination. Latency is fixed for all operands, including zero.

## Test plan
- Unsigned 3*5: accept at T. Required: stall_out high T..T+32, result_valid only at T+33, hi=0x00000000, lo=0x0000000F, result_dest equals the dest_ex sampled at T.
- Signed -1*2 (0xFFFFFFFF, 0x00000002): required hi=0xFFFFFFFF, lo=0xFFFFFFFE. Unsigned 0xFFFFFFFF*0xFFFFFFFF: required hi=0xFFFFFFFE, lo=0x00000001.
- Signed 0x80000000*0x80000000: required hi=0x40000000, lo=0x00000000. Signed 0x80000000*0x00000001: required hi=0xFFFFFFFF, lo=0x80000000.
- flush at RUN step 10: required stall_out=0 in that cycle, no result_valid, result outputs unchanged. A new multiply presented the next cycle is accepted and completes 33 cycles later.
- Two consecutive multiplies, with mul_ex_in held high through DONE: required exactly one result_valid per instruction, the second accepted at T+34, and no re-accept in DONE.
- reset asserted at RUN step 20 and in DONE: required all outputs 0 on the next cycle, with stall_out=0 while reset=1.
